framebuffer_write: RTL and testbench



---
 rtl/framebuffer_write.sv | 103 ++++++++++
 tb/tb_framebuffer_write.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/framebuffer_write.sv
// framebuffer_write: assembles a byte stream into RGB565 pixels and writes one 64x32 frame into the framebuffer RAM
//   clk_in           system clock, all logic on posedge
//   reset            synchronous active-high reset
//   frame_start      one-cycle strobe, arms the writer at pixel 0
//   data_in          stream byte
//   data_valid       data_in valid this cycle
//   ram_address      {half, row[3:0], ~col[5:0]} of the pixel being written
//   ram_data_out     RGB565 pixel
//   ram_write_enable one-cycle write strobe
//   ram_clk_enable   copy of ram_write_enable
//   busy             high from frame_start until frame_done
//   frame_done       one-cycle pulse after the 2048th write
module framebuffer_write #(
   parameter bit HIGH_BYTE_FIRST = 1'b1
) (
   input  logic        clk_in,
   input  logic        reset,
   input  logic        frame_start,
   input  logic [7:0]  data_in,
   input  logic        data_valid,
   output logic [10:0] ram_address,
   output logic [15:0] ram_data_out,
   output logic        ram_write_enable,
   output logic        ram_clk_enable,
   output logic        busy,
   output logic        frame_done
);
   typedef enum logic [2:0] {S_IDLE, S_FIRST, S_SECOND, S_WRITE, S_DONE} state_t;
   state_t      r_state;
   logic [10:0] r_cnt;
   logic [7:0]  r_byte;
   logic [10:0] r_addr;
   logic [15:0] r_data;
   logic        r_we;
   logic        r_busy;
   logic        r_done;
   logic [10:0] w_addr;
   logic [15:0] w_pixel;
   // the scan-out reader walks columns right to left, hence the inverted column field
   assign w_addr  = {r_cnt[10], r_cnt[9:6], ~r_cnt[5:0]};
   assign w_pixel = HIGH_BYTE_FIRST ? {r_byte, data_in} : {data_in, r_byte};
   always_ff @(posedge clk_in) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_byte  <= '0;
         r_addr  <= '0;
         r_data  <= '0;
         r_we    <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else if (frame_start) begin
         r_state <= S_FIRST;
         r_cnt   <= '0;
         r_we    <= 1'b0;
         r_busy  <= 1'b1;
         r_done  <= 1'b0;
      end else begin
         r_we   <= 1'b0;
         r_done <= 1'b0;
         case (r_state)
            S_FIRST:
               if (data_valid) begin
                  r_byte  <= data_in;
                  r_state <= S_SECOND;
               end
            S_SECOND:
               if (data_valid) begin
                  r_addr  <= w_addr;
                  r_data  <= w_pixel;
                  r_we    <= 1'b1;
                  r_state <= S_WRITE;
               end
            S_WRITE:
               if (r_cnt == 11'd2047) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + 11'd1;
                  // a byte arriving during the strobe already starts the next pixel
                  if (data_valid) begin
                     r_byte  <= data_in;
                     r_state <= S_SECOND;
                  end else begin
                     r_state <= S_FIRST;
                  end
               end
            S_DONE: begin
               r_cnt   <= '0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
   assign ram_address      = r_addr;
   assign ram_data_out     = r_data;
   assign ram_write_enable = r_we;
   assign ram_clk_enable   = r_we;
   assign busy             = r_busy;
   assign frame_done       = r_done;
endmodule

// File: tb/tb_framebuffer_write.sv
// tb_framebuffer_write: randomized and directed checks of framebuffer_write against a raster-order pixel model
module tb_framebuffer_write;
   typedef struct packed {logic [10:0] a; logic [15:0] d;} wr_t;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic fs = 1'b0;
   logic [7:0] din = '0;
   logic dv = 1'b0;
   logic [10:0] a1, a0;
   logic [15:0] d1, d0;
   logic we1, ce1, busy1, done1, we0, ce0, busy0, done0;
   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int last_we_cyc = 0;
   int done_cyc = 0;
   int done_cnt = 0;
   logic done_busy = 1'b0;
   wr_t obs[$];
   wr_t exp_q[$];
   bit seen[2048];
   int uniq;
   logic [7:0] f, s;
   framebuffer_write #(.HIGH_BYTE_FIRST(1'b1)) dut1 (
      .clk_in(clk), .reset(rst), .frame_start(fs), .data_in(din), .data_valid(dv),
      .ram_address(a1), .ram_data_out(d1), .ram_write_enable(we1), .ram_clk_enable(ce1),
      .busy(busy1), .frame_done(done1));
   framebuffer_write #(.HIGH_BYTE_FIRST(1'b0)) dut0 (
      .clk_in(clk), .reset(rst), .frame_start(fs), .data_in(din), .data_valid(dv),
      .ram_address(a0), .ram_data_out(d0), .ram_write_enable(we0), .ram_clk_enable(ce0),
      .busy(busy0), .frame_done(done0));
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   function automatic void check(string tag, logic [31:0] o, logic [31:0] e);
      n_cmp++;
      assert (o === e) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, o, e);
      end
   endfunction
   // raster index -> RAM address from the layout rules, columns stored mirrored
   function automatic logic [10:0] model_addr(int p);
      int y = p / 64;
      int x = p % 64;
      return 11'((y / 16) * 1024 + (y % 16) * 64 + (63 - x));
   endfunction
   always @(negedge clk) begin
      check("clk_en1", 32'(ce1), 32'(we1));
      check("clk_en0", 32'(ce0), 32'(we0));
      if (we1) begin
         obs.push_back({a1, d1});
         last_we_cyc = cyc;
      end
      if (done1) begin
         done_cnt++;
         done_cyc = cyc;
         done_busy = busy1;
      end
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic smp();
      @(negedge clk);
      #1;
   endtask
   task automatic put(input logic [7:0] b);
      din = b;
      dv = 1'b1;
      tick();
      dv = 1'b0;
   endtask
   task automatic start();
      fs = 1'b1;
      tick();
      fs = 1'b0;
   endtask
   task automatic check_reset(string tag);
      check({tag, "_addr"}, 32'(a1), 32'h000);
      check({tag, "_data"}, 32'(d1), 32'h0000);
      check({tag, "_we"}, 32'(we1), 32'h0);
      check({tag, "_ce"}, 32'(ce1), 32'h0);
      check({tag, "_busy"}, 32'(busy1), 32'h0);
      check({tag, "_done"}, 32'(done1), 32'h0);
   endtask
   task automatic wait_done(string tag);
      for (int i = 0; i < 10 && done_cnt == 0; i++) begin
         smp();
         if (done_cnt == 0) tick();
      end
      check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
      check({tag, "_done_lat"}, 32'(done_cyc), 32'(last_we_cyc + 1));
      check({tag, "_done_busy"}, 32'(done_busy), 32'h0);
      tick();
      smp();
      check({tag, "_busy_after"}, 32'(busy1), 32'h0);
      check({tag, "_done_pulse"}, 32'(done1), 32'h0);
      check({tag, "_done_once"}, 32'(done_cnt), 32'd1);
   endtask
   task automatic check_frame(string tag);
      check({tag, "_nwrites"}, 32'(obs.size()), 32'(exp_q.size()));
      for (int i = 0; i < 2048; i++) seen[i] = 1'b0;
      uniq = 0;
      for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
         check({tag, "_wr"}, 32'(obs[i]), 32'(exp_q[i]));
         if (!seen[obs[i].a]) uniq++;
         seen[obs[i].a] = 1'b1;
      end
      check({tag, "_unique"}, 32'(uniq), 32'd2048);
   endtask
   initial begin
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      smp();
      check_reset("rst");
      // first pixel
      obs.delete();
      start();
      smp();
      check("busy_rise", 32'(busy1), 32'h1);
      put(8'hF8);
      put(8'h00);
      smp();
      check("p0_we", 32'(we1), 32'h1);
      check("p0_addr", 32'(a1), 32'h03F);
      check("p0_data", 32'(d1), 32'hF800);
      check("p0_busy", 32'(busy1), 32'h1);
      tick();
      smp();
      check("p0_we_once", 32'(we1), 32'h0);
      check("p0_hold_addr", 32'(a1), 32'h03F);
      // full frame at full rate, pixel p = p
      start();
      obs.delete();
      exp_q.delete();
      done_cnt = 0;
      for (int p = 0; p < 2048; p++) begin
         exp_q.push_back({model_addr(p), 16'(p)});
         put(8'(p >> 8));
         put(8'(p & 255));
      end
      wait_done("full");
      check_frame("full");
      if (obs.size() == 2048) check("last_addr", 32'(obs[2047].a), 32'h7C0);
      // low byte first variant
      start();
      put(8'h34);
      put(8'h12);
      smp();
      check("lbf_we", 32'(we0), 32'h1);
      check("lbf_data", 32'(d0), 32'h1234);
      check("lbf_addr", 32'(a0), 32'h03F);
      check("hbf_data", 32'(d1), 32'h3412);
      // stray byte discarded by frame_start
      start();
      for (int i = 0; i < 3; i++) put(8'($urandom));
      start();
      obs.delete();
      put(8'hAB);
      put(8'hCD);
      smp();
      tick();
      smp();
      check("stray_nwr", 32'(obs.size()), 32'd1);
      if (obs.size() > 0) check("stray_wr", 32'(obs[0]), {5'd0, 11'h03F, 16'hABCD});
      // frame_start together with the second byte cancels the write
      start();
      put(8'h11);
      obs.delete();
      din = 8'h22;
      dv = 1'b1;
      fs = 1'b1;
      tick();
      fs = 1'b0;
      dv = 1'b0;
      tick();
      tick();
      smp();
      check("cancel_nwr", 32'(obs.size()), 32'd0);
      check("cancel_busy", 32'(busy1), 32'h1);
      put(8'h5A);
      put(8'hC3);
      smp();
      check("cancel_next", 32'({a1, d1}), {5'd0, 11'h03F, 16'h5AC3});
      // reset between the two bytes of pixel 5
      start();
      obs.delete();
      for (int i = 0; i < 11; i++) put(8'($urandom));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      smp();
      check_reset("midrst");
      check("midrst_nwr", 32'(obs.size()), 32'd5);
      put(8'h77);
      put(8'h88);
      tick();
      smp();
      check("midrst_nowr", 32'(obs.size()), 32'd5);
      start();
      put(8'h9C);
      put(8'h4E);
      smp();
      check("midrst_next", 32'({a1, d1}), {5'd0, 11'h03F, 16'h9C4E});
      // idle ignores traffic
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 100; i++) begin
         din = 8'($urandom);
         dv = 1'($urandom);
         tick();
         smp();
         check("idle_we", 32'(we1), 32'h0);
         check("idle_busy", 32'(busy1), 32'h0);
      end
      dv = 1'b0;
      // random data with random gaps
      start();
      obs.delete();
      exp_q.delete();
      done_cnt = 0;
      for (int p = 0; p < 2048; p++) begin
         f = 8'($urandom);
         s = 8'($urandom);
         exp_q.push_back({model_addr(p), 16'(f * 256 + s)});
         repeat ($urandom_range(0, 2)) tick();
         put(f);
         repeat ($urandom_range(0, 2)) tick();
         put(s);
      end
      wait_done("rand");
      check_frame("rand");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
